// File: rtl/tl_ul_mem_slave.sv
// TileLink-UL memory responder: one outstanding request, word-addressed RAM,
// fixed response latency set by the LATENCY parameter, and error responses
// for requests that cannot be serviced.
module tl_ul_mem_slave #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    SRC_WIDTH    = 1,
  parameter int                    SINK_WIDTH   = 1,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter int                    DEPTH_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    LATENCY      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int LANE_BITS = $clog2(MASK_WIDTH);
  localparam int IDX_BITS  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LP_END =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH_WORDS * MASK_WIDTH);
  localparam logic [7:0] LP_LAT = 8'(LATENCY);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  logic [7:0]              r_cnt;
  logic                    r_d_valid;
  logic [OPCODE_WIDTH-1:0] r_d_opcode;
  logic [SIZE_WIDTH-1:0]   r_d_size;
  logic [SRC_WIDTH-1:0]    r_d_source;
  logic [DATA_WIDTH-1:0]   r_d_data;
  logic                    r_d_error;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0]   w_offset;
  logic [ADDR_WIDTH-1:0]   w_align_mask;
  logic [ADDR_WIDTH-1:0]   w_lane_off;
  logic [MASK_WIDTH-1:0]   w_full_mask;
  logic [IDX_BITS-1:0]     w_idx;
  logic                    w_op_get;
  logic                    w_op_put;
  logic                    w_in_range;
  logic                    w_size_ok;
  logic                    w_aligned;
  logic                    w_mask_ok;
  logic                    w_err;
  logic                    w_accept;
  logic                    w_unused;

  // Decode the incoming request: word index and every error condition
  always_comb begin
    w_offset     = a_address - BASE_ADDR;
    w_idx        = w_offset[LANE_BITS +: IDX_BITS];
    w_op_get     = (a_opcode == OP_GET);
    w_op_put     = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
    w_in_range   = ({1'b0, a_address} >= {1'b0, BASE_ADDR}) && ({1'b0, a_address} < LP_END);
    w_size_ok    = (a_size <= SIZE_WIDTH'(LANE_BITS));
    w_align_mask = (ADDR_WIDTH'(1) << a_size) - ADDR_WIDTH'(1);
    w_aligned    = ((a_address & w_align_mask) == '0);
    w_lane_off   = a_address & ADDR_WIDTH'(MASK_WIDTH - 1);
    // 2^size contiguous lanes; a full-width transfer wraps the shift to zero,
    // so the subtraction yields all ones as required.
    w_full_mask  = ((MASK_WIDTH'(1) << (ADDR_WIDTH'(1) << a_size)) - MASK_WIDTH'(1)) << w_lane_off;
    w_mask_ok    = (a_opcode != OP_PUT_FULL) || (a_mask == w_full_mask);
    w_err        = !(w_op_get || w_op_put) || !w_in_range || !w_size_ok
                   || !w_aligned || !w_mask_ok;
  end

  assign w_accept = a_valid && (r_state == S_IDLE) && !reset;
  assign w_unused = ^{a_param, w_offset};

  // Request/response FSM with registered response fields and latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_d_valid  <= 1'b0;
      r_d_opcode <= '0;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_d_size   <= a_size;
            r_d_source <= a_source;
            r_d_error  <= w_err;
            r_d_opcode <= w_op_get ? OPCODE_WIDTH'(1) : '0;
            r_d_data   <= (w_op_get && !w_err) ? r_mem[w_idx] : '0;
            if (LATENCY == 0) begin
              r_state   <= S_RESP;
              r_d_valid <= 1'b1;
            end else begin
              r_cnt   <= LP_LAT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state   <= S_RESP;
            r_d_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (r_d_valid && d_ready) begin
            r_d_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-lane RAM write on an accepted, error-free Put; reset leaves contents
  always_ff @(posedge clk) begin
    if (w_accept && w_op_put && !w_err) begin
      for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
        if (a_mask[i]) r_mem[w_idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  assign a_ready  = (r_state == S_IDLE);
  assign d_valid  = r_d_valid;
  assign d_opcode = r_d_opcode;
  assign d_param  = '0;
  assign d_size   = r_d_size;
  assign d_source = r_d_source;
  assign d_sink   = '0;
  assign d_data   = r_d_data;
  assign d_error  = r_d_error;

endmodule

// File: tb/tb_tl_ul_mem_slave.sv
// Self-checking bench: three responders with latencies 0, 3 and 5, directed
// scenarios followed by randomized traffic against a byte-array memory model.
module tb_tl_ul_mem_slave;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NI];
  logic        a_valid   [NI];
  logic        a_ready   [NI];
  logic [2:0]  a_opcode  [NI];
  logic [2:0]  a_param   [NI];
  logic [2:0]  a_size    [NI];
  logic        a_source  [NI];
  logic [31:0] a_address [NI];
  logic [3:0]  a_mask    [NI];
  logic [31:0] a_data    [NI];
  logic        d_valid   [NI];
  logic        d_ready   [NI];
  logic [2:0]  d_opcode  [NI];
  logic [2:0]  d_param   [NI];
  logic [2:0]  d_size    [NI];
  logic        d_source  [NI];
  logic        d_sink    [NI];
  logic [31:0] d_data    [NI];
  logic        d_error   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    tl_ul_mem_slave #(
      .LATENCY(g == 0 ? 0 : (g == 1 ? 3 : 5))
    ) u_dut (
      .clk(clk), .reset(rst[g]),
      .a_valid(a_valid[g]), .a_ready(a_ready[g]), .a_opcode(a_opcode[g]),
      .a_param(a_param[g]), .a_size(a_size[g]), .a_source(a_source[g]),
      .a_address(a_address[g]), .a_mask(a_mask[g]), .a_data(a_data[g]),
      .d_valid(d_valid[g]), .d_ready(d_ready[g]), .d_opcode(d_opcode[g]),
      .d_param(d_param[g]), .d_size(d_size[g]), .d_source(d_source[g]),
      .d_sink(d_sink[g]), .d_data(d_data[g]), .d_error(d_error[g])
    );
  end

  int nvec = 0;
  int nerr = 0;
  logic [7:0] ref_mem [NI][1024];

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 3 : 5);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: applies the request to the byte array and returns the response
  task automatic model(input int i, input int op, input int sz, input longint addr,
                       input logic [3:0] mask, input logic [31:0] data,
                       output logic e_err, output logic [2:0] e_op, output logic [31:0] e_data);
    int nbytes;
    longint base;
    e_err = 1'b0;
    if (!(op == 0 || op == 1 || op == 4)) e_err = 1'b1;
    if (addr >= 1024) e_err = 1'b1;
    if (sz > 2) e_err = 1'b1;
    else begin
      nbytes = 1 << sz;
      if (addr % nbytes != 0) e_err = 1'b1;
      else if (op == 0 && int'(mask) != (((1 << nbytes) - 1) << (addr % 4))) e_err = 1'b1;
    end
    e_op   = (op == 4) ? 3'd1 : 3'd0;
    e_data = '0;
    if (!e_err) begin
      base = (addr / 4) * 4;
      for (int k = 0; k < 4; k++) begin
        if (op == 4) e_data[8*k +: 8] = ref_mem[i][base + k];
        else if (mask[k]) ref_mem[i][base + k] = data[8*k +: 8];
      end
    end
  endtask

  task automatic txn(input int i, input int op, input int sz, input int src,
                     input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                     input int hold, output logic [31:0] o_data, output logic o_err);
    logic e_err;
    logic [2:0] e_op;
    logic [31:0] e_data;
    logic [63:0] snap;
    int n;
    model(i, op, sz, {32'b0, addr}, mask, data, e_err, e_op, e_data);
    chk("a_ready_idle", 64'(a_ready[i]), 64'd1);
    a_opcode[i] = 3'(op); a_size[i] = 3'(sz); a_source[i] = 1'(src);
    a_address[i] = addr; a_mask[i] = mask; a_data[i] = data; a_param[i] = 3'($urandom);
    a_valid[i] = 1'b1;
    @(posedge clk); #1;
    a_valid[i] = 1'b0;
    a_data[i] = $urandom; a_address[i] = $urandom; a_size[i] = 3'($urandom); a_source[i] = ~a_source[i];
    chk("a_ready_busy", 64'(a_ready[i]), 64'd0);
    n = 1;
    while (d_valid[i] !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat_of(i) + 1));
    chk("d_opcode", 64'(d_opcode[i]), 64'(e_op));
    chk("d_error", 64'(d_error[i]), 64'(e_err));
    chk("d_data", 64'(d_data[i]), 64'(e_data));
    chk("d_size", 64'(d_size[i]), 64'(sz));
    chk("d_source", 64'(d_source[i]), 64'(src));
    chk("d_param_sink", 64'({d_param[i], d_sink[i]}), 64'd0);
    o_data = d_data[i];
    o_err  = d_error[i];
    snap = 64'({d_opcode[i], d_param[i], d_size[i], d_source[i], d_sink[i], d_data[i], d_error[i]});
    for (int k = 0; k < hold; k++) begin
      a_opcode[i] = 3'd0; a_size[i] = 3'd2; a_mask[i] = 4'hF;
      a_address[i] = 32'($urandom_range(0, 255) * 4); a_data[i] = $urandom;
      a_valid[i] = 1'b1;
      @(posedge clk); #1;
      chk("hold_stable", 64'({d_opcode[i], d_param[i], d_size[i], d_source[i], d_sink[i], d_data[i], d_error[i]}), snap);
      chk("hold_valid", 64'(d_valid[i]), 64'd1);
      chk("hold_a_ready", 64'(a_ready[i]), 64'd0);
    end
    a_valid[i] = 1'b0;
    d_ready[i] = 1'b1;
    @(posedge clk); #1;
    d_ready[i] = 1'b0;
    chk("d_valid_drop", 64'(d_valid[i]), 64'd0);
    chk("a_ready_back", 64'(a_ready[i]), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] od;
    logic oe;
    logic [3:0] m;
    int op, sz, a, hold;

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; a_valid[i] = 1'b0; d_ready[i] = 1'b0; a_opcode[i] = '0; a_param[i] = '0;
      a_size[i] = '0; a_source[i] = '0; a_address[i] = '0; a_mask[i] = '0; a_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("rst_a_ready", 64'(a_ready[i]), 64'd1);
      chk("rst_d_valid", 64'(d_valid[i]), 64'd0);
      chk("rst_d_fields", 64'({d_opcode[i], d_param[i], d_size[i], d_source[i], d_sink[i], d_data[i], d_error[i]}), 64'd0);
    end

    // Directed: full write, read back, latency-3 read, partial write
    txn(0, 0, 2, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, od, oe);
    txn(0, 4, 2, 0, 32'h10, 4'hF, 32'h0, 0, od, oe);
    chk("get_deadbeef", 64'(od), 64'hDEADBEEF);
    txn(1, 0, 2, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, od, oe);
    txn(1, 4, 2, 1, 32'h10, 4'hF, 32'h0, 0, od, oe);
    chk("get_lat3", 64'(od), 64'hDEADBEEF);
    txn(0, 1, 2, 0, 32'h10, 4'h2, 32'h0000AA00, 0, od, oe);
    txn(0, 4, 2, 0, 32'h10, 4'hF, 32'h0, 0, od, oe);
    chk("get_partial", 64'(od), 64'hDEADAAEF);

    // Directed: error cases
    txn(0, 4, 2, 0, 32'h400, 4'hF, 32'h0, 0, od, oe);
    chk("err_range", 64'({oe, od}), 64'({1'b1, 32'h0}));
    txn(0, 0, 2, 0, 32'h12, 4'hF, 32'h11111111, 0, od, oe);
    chk("err_misalign", 64'(oe), 64'd1);
    txn(0, 4, 2, 0, 32'h10, 4'hF, 32'h0, 0, od, oe);
    chk("ram_unchanged", 64'(od), 64'hDEADAAEF);
    txn(0, 2, 2, 0, 32'h10, 4'hF, 32'h0, 0, od, oe);
    chk("err_opcode", 64'(oe), 64'd1);

    // Directed: back-pressure with an ignored request during the hold
    txn(0, 4, 2, 1, 32'h10, 4'hF, 32'h0, 5, od, oe);

    // Directed: reset while waiting (latency 5) keeps the accepted Put
    model(2, 0, 2, 64'h20, 4'hF, 32'h12345678, oe, a_opcode[2], od);
    a_opcode[2] = 3'd0; a_size[2] = 3'd2; a_source[2] = 1'b0;
    a_address[2] = 32'h20; a_mask[2] = 4'hF; a_data[2] = 32'h12345678;
    a_valid[2] = 1'b1;
    @(posedge clk); #1;
    a_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    chk("rstwait_a_ready", 64'(a_ready[2]), 64'd1);
    for (int k = 0; k < 8; k++) begin
      chk("rstwait_no_valid", 64'(d_valid[2]), 64'd0);
      @(posedge clk); #1;
    end
    txn(2, 4, 2, 0, 32'h20, 4'hF, 32'h0, 0, od, oe);
    chk("rstwait_put_kept", 64'(od), 64'h12345678);

    // Fill every word of each model/RAM pair so random reads are defined
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < 256; w++)
        txn(i, 0, 2, w % 2, 32'(w * 4), 4'hF, $urandom, 0, od, oe);

    // Randomized traffic
    for (int i = 0; i < NI; i++) begin
      for (int t = 0; t < 60; t++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: op = 4;
          3, 4, 5: op = 0;
          6, 7:    op = 1;
          default: op = int'($urandom_range(0, 7));
        endcase
        sz = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : 3;
        a  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1024, 70000)) : int'($urandom_range(0, 1023));
        if (sz <= 2 && $urandom_range(0, 3) != 0) a = a - (a % (1 << sz));
        if (sz <= 2 && $urandom_range(0, 3) != 0) m = 4'(((1 << (1 << sz)) - 1) << (a % 4));
        else m = 4'($urandom);
        hold = int'($urandom_range(0, 2));
        txn(i, op, sz, int'($urandom_range(0, 1)), 32'(a), m, $urandom, hold, od, oe);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
